// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: per-source result handshake in, registered broadcast out.
// slave = arbiter side; master = result sources plus broadcast listeners.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4,
  parameter int SRC_NUM = 3
);
  logic [SRC_NUM-1:0] srcValid;
  logic [SRC_NUM-1:0] srcReady;
  logic [SRC_NUM*ROB_WIDTH-1:0] srcRobIndex;
  logic [SRC_NUM*32-1:0] srcValue;
  logic cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobIndex;
  logic [31:0] cdbValue;
  logic [1:0] cdbSource;

  modport slave (
    input  srcValid, srcRobIndex, srcValue,
    output srcReady,
    output cdbValid, cdbRobIndex, cdbValue, cdbSource
  );

  modport master (
    output srcValid, srcRobIndex, srcValue,
    input  srcReady,
    input  cdbValid, cdbRobIndex, cdbValue, cdbSource
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: 3 sources, 2-entry FIFO each, round-robin pick.
// Ports: clockIn, resetIn (sync, high), readyIn (enable), clear (flush), bus.
module cdb_arbiter #(
  parameter int ROB_WIDTH = 4,
  parameter int SRC_NUM = 3,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic clockIn,
  input  logic resetIn,
  input  logic readyIn,
  input  logic clear,
  cdb_arbiter_if.slave bus
);

  logic [ROB_WIDTH-1:0] qIdx [SRC_NUM][QUEUE_DEPTH];
  logic [31:0] qVal [SRC_NUM][QUEUE_DEPTH];
  logic [1:0] count [SRC_NUM];
  logic head [SRC_NUM];
  logic [1:0] rrPtr;

  logic found;
  logic [1:0] winner;
  logic [SRC_NUM-1:0] push;
  logic [SRC_NUM-1:0] pop;

  // Ready looks only at the stored count, so a full queue stays
  // unready even on a cycle where it is also being popped.
  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      bus.srcReady[i] = count[i] < 2'(QUEUE_DEPTH);
    end
  end

  // First nonempty queue starting at rrPtr, wrapping mod 3.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] cand;
    found = 1'b0;
    winner = rrPtr;
    sum = 3'd0;
    cand = 2'd0;
    for (int k = 0; k < SRC_NUM; k++) begin
      sum = {1'b0, rrPtr} + 3'(k);
      if (sum >= 3'(SRC_NUM)) sum = sum - 3'(SRC_NUM);
      cand = sum[1:0];
      if (!found && count[cand] != 2'd0) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      push[i] = bus.srcValid[i] && bus.srcReady[i];
      pop[i] = found && (winner == 2'(i));
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        count[i] <= 2'd0;
        head[i] <= 1'b0;
      end
      rrPtr <= 2'd0;
      bus.cdbValid <= 1'b0;
      bus.cdbRobIndex <= '0;
      bus.cdbValue <= 32'd0;
      bus.cdbSource <= 2'd0;
    end else if (clear) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        count[i] <= 2'd0;
        head[i] <= 1'b0;
      end
      rrPtr <= 2'd0;
      bus.cdbValid <= 1'b0;
    end else if (readyIn) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        // Tail slot is head + count; only 2 slots, so a 1-bit xor.
        if (push[i]) begin
          qIdx[i][head[i] ^ count[i][0]] <=
            bus.srcRobIndex[i*ROB_WIDTH +: ROB_WIDTH];
          qVal[i][head[i] ^ count[i][0]] <=
            bus.srcValue[i*32 +: 32];
        end
        if (pop[i]) head[i] <= ~head[i];
        if (push[i] && !pop[i]) count[i] <= count[i] + 2'd1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 2'd1;
      end
      if (found) begin
        bus.cdbValid <= 1'b1;
        bus.cdbRobIndex <= qIdx[winner][head[winner]];
        bus.cdbValue <= qVal[winner][head[winner]];
        bus.cdbSource <= winner;
        rrPtr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
      end else begin
        bus.cdbValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues
// filled on accept, popped in round-robin order on each broadcast.
module tb_cdb_arbiter;
  localparam int RW = 4;

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [31:0] val;
  } ent_t;

  logic clockIn = 1'b0;
  logic resetIn, readyIn, clear;

  cdb_arbiter_if #(.ROB_WIDTH(RW), .SRC_NUM(3)) bus ();

  cdb_arbiter #(.ROB_WIDTH(RW)) dut (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .readyIn(readyIn),
    .clear(clear),
    .bus(bus)
  );

  always #5 clockIn = ~clockIn;

  ent_t sq [3][$];
  int rr = 0;
  logic expValid = 1'b0;
  logic [RW-1:0] expIdx = '0;
  logic [31:0] expVal = '0;
  logic [1:0] expSrc = '0;
  logic [2:0] lastAcc = '0;
  int seq = 0;
  int vecCount = 0;
  int missCount = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] acc;
    logic [2:0] er;
    int w;
    int c;
    ent_t e;
    for (int i = 0; i < 3; i++)
      acc[i] = bus.srcValid[i] && (sq[i].size() < 2) &&
               readyIn && !clear && !resetIn;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      c = (rr + k) % 3;
      if (w < 0 && sq[c].size() > 0) w = c;
    end
    @(posedge clockIn);
    #1;
    if (resetIn) begin
      for (int i = 0; i < 3; i++) sq[i].delete();
      rr = 0;
      expValid = 0; expIdx = '0; expVal = '0; expSrc = '0;
      acc = '0;
    end else if (clear) begin
      for (int i = 0; i < 3; i++) sq[i].delete();
      rr = 0;
      expValid = 0;
    end else if (readyIn) begin
      if (w >= 0) begin
        e = sq[w].pop_front();
        expValid = 1;
        expIdx = e.idx;
        expVal = e.val;
        expSrc = 2'(w);
        rr = (w + 1) % 3;
      end else begin
        expValid = 0;
      end
      for (int i = 0; i < 3; i++)
        if (acc[i])
          sq[i].push_back({bus.srcRobIndex[i*RW +: RW],
                           bus.srcValue[i*32 +: 32]});
    end
    lastAcc = acc;
    for (int i = 0; i < 3; i++) er[i] = sq[i].size() < 2;
    chk("cdbValid", 64'(bus.cdbValid), 64'(expValid));
    chk("cdbRobIndex", 64'(bus.cdbRobIndex), 64'(expIdx));
    chk("cdbValue", 64'(bus.cdbValue), 64'(expVal));
    chk("cdbSource", 64'(bus.cdbSource), 64'(expSrc));
    chk("srcReady", 64'(bus.srcReady), 64'(er));
  endtask

  task automatic setEntry(input int i, input logic on,
                          input logic [RW-1:0] idx,
                          input logic [31:0] val);
    bus.srcValid[i] = on;
    bus.srcRobIndex[i*RW +: RW] = idx;
    bus.srcValue[i*32 +: 32] = val;
  endtask

  task automatic newEntry(input int i, input logic on);
    logic [31:0] r;
    r = $urandom;
    setEntry(i, on, RW'($urandom_range(0, 15)),
             {seq[11:0], r[19:0]});
    seq++;
  endtask

  // Sources hold their offer until accepted, then move to a new one.
  task automatic refresh(input logic [2:0] want);
    for (int i = 0; i < 3; i++)
      if (!bus.srcValid[i] || lastAcc[i]) newEntry(i, want[i]);
  endtask

  task automatic idle(input int n);
    bus.srcValid = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic doReset();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
  endtask

  initial begin
    logic sawFull;
    logic sawValid;
    resetIn = 1'b1; readyIn = 1'b1; clear = 1'b0;
    bus.srcValid = '0;
    bus.srcRobIndex = '0;
    bus.srcValue = '0;
    tick();
    tick();
    resetIn = 1'b0;
    idle(1);

    // single source
    setEntry(1, 1'b1, 4'd5, 32'hDEADBEEF);
    tick();
    idle(4);

    // three-way contention from rrPtr = 0
    doReset();
    setEntry(0, 1'b1, 4'd1, 32'h1111_0001);
    setEntry(1, 1'b1, 4'd2, 32'h2222_0002);
    setEntry(2, 1'b1, 4'd3, 32'h3333_0003);
    tick();
    idle(5);

    // back-pressure on src0 with src2 also busy
    sawFull = 1'b0;
    lastAcc = '0;
    bus.srcValid = '0;
    refresh(3'b101);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.srcReady[0] === 1'b0) sawFull = 1'b1;
      refresh(3'b101);
    end
    chk("bp_src0_full", 64'(sawFull), 64'd1);
    idle(8);

    // stall with nonempty queues
    refresh(3'b111);
    for (int k = 0; k < 2; k++) begin
      tick();
      refresh(3'b111);
    end
    bus.srcValid = '0;
    readyIn = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    readyIn = 1'b1;
    idle(8);

    // flush with readyIn low, same-edge offers dropped
    refresh(3'b111);
    for (int k = 0; k < 5; k++) begin
      tick();
      refresh(3'b111);
    end
    readyIn = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    readyIn = 1'b1;
    idle(6);

    // reset while a broadcast is on the bus
    sawValid = 1'b0;
    refresh(3'b111);
    for (int k = 0; k < 6 && !sawValid; k++) begin
      tick();
      refresh(3'b111);
      if (bus.cdbValid === 1'b1) sawValid = 1'b1;
    end
    chk("rst_burst_hit", 64'(sawValid), 64'd1);
    doReset();
    bus.srcValid = '0;
    setEntry(2, 1'b1, 4'd9, 32'hCAFE_0009);
    tick();
    idle(4);

    // random traffic with stalls, flushes and resets
    lastAcc = '0;
    for (int k = 0; k < 400; k++) begin
      refresh(3'($urandom_range(0, 7)));
      readyIn = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 39) == 0);
      resetIn = ($urandom_range(0, 99) == 0);
      tick();
    end
    resetIn = 1'b0; clear = 1'b0; readyIn = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecCount, missCount);
    $finish;
  end
endmodule
